mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 139 +++++++++++++
 tb/tb_mdu_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: multi-cycle mult/div into HI/LO with busy interlock.
// Optional macro MDU_MADD_EN enables madd/maddu (ops 9/10) accumulating into {HI,LO}.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int unsigned DW      = 32;
  localparam int unsigned OPW     = 4;
  localparam int unsigned CW      = 4;
  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 10;

  localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(7);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(8);
  localparam logic [OPW-1:0] OP_MADD  = OPW'(9);
  localparam logic [OPW-1:0] OP_MADDU = OPW'(10);

  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]   hi_d, lo_d;

  logic            is_mul, is_div, is_acc;
  logic            op_signed;
  logic [2*DW-1:0] mul_a, mul_b, prod;
  logic signed [DW:0] div_a, div_b, div_d, quot, rem;

  // Decode of the incoming E-stage opcode for acceptance.
  always_comb begin
    is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    is_acc = 1'b0;
`ifdef MDU_MADD_EN
    is_acc = (md_op == OP_MADD) || (md_op == OP_MADDU);
`endif
  end

  assign start = (is_mul | is_div | is_acc) & ~busy & ~cancel;

  // Datapath works only on latched operands; 33-bit signed divide covers
  // both signednesses and the 0x80000000 / -1 overflow case.
  always_comb begin
    op_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
    mul_a = op_signed ? (2*DW)'(signed'(a_q)) : (2*DW)'(a_q);
    mul_b = op_signed ? (2*DW)'(signed'(b_q)) : (2*DW)'(b_q);
    prod  = mul_a * mul_b;
    div_a = op_signed ? (DW+1)'(signed'(a_q)) : (DW+1)'(a_q);
    div_b = op_signed ? (DW+1)'(signed'(b_q)) : (DW+1)'(b_q);
    div_d = (b_q == '0) ? (DW+1)'(1) : div_b;
    quot  = div_a / div_d;
    rem   = div_a % div_d;
  end

  // Next-state: accept, count down and retire, or service mthi/mtlo.
  always_comb begin
    cnt_d  = cnt;
    busy_d = busy;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi;
    lo_d   = lo;
    if (start) begin
      op_d   = md_op;
      a_d    = src_a;
      b_d    = src_b;
      cnt_d  = is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      busy_d = 1'b1;
    end else if (busy) begin
      cnt_d  = cnt - CW'(1);
      busy_d = (cnt != CW'(1));
      if (cnt == CW'(1)) begin
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
          OP_DIV, OP_DIVU: begin
            if (b_q != '0) begin
              hi_d = DW'(rem);
              lo_d = DW'(quot);
            end
          end
          OP_MADD, OP_MADDU: begin
`ifdef MDU_MADD_EN
            {hi_d, lo_d} = {hi, lo} + prod;
`endif
          end
          default: ;
        endcase
      end
    end else if (!cancel) begin
      if (md_op == OP_MTHI) hi_d = src_a;
      if (md_op == OP_MTLO) lo_d = src_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      cnt  <= cnt_d;
      busy <= busy_d;
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      hi   <= hi_d;
      lo   <= lo_d;
    end
  end

  // Read port reflects committed HI/LO only.
  always_comb begin
    md_rdata = '0;
    if (md_op == OP_MFHI) md_rdata = hi;
    else if (md_op == OP_MFLO) md_rdata = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for mult/div results and latency,
// plus hand sequences for zero divide, hazards, cancel, reset abort and madd.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        start, busy;
  logic [31:0] hi, lo, md_rdata;

  int nvec = 0;
  int nerr = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .start(start), .busy(busy), .hi(hi), .lo(lo),
    .md_rdata(md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op for a cycle, check start, then return to op 0.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_start, input string nm);
    md_op = op;
    src_a = a;
    src_b = b;
    #1;
    chk({nm, " start"}, 32'(start), 32'(exp_start));
    tick();
    md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[3] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[4] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7] = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[8] = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};

    reset = 1'b0; md_op = 4'd0; src_a = '0; src_b = '0; cancel = 1'b0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    md_op = 4'd8;
    #1;
    chk("rst mflo", md_rdata, 32'd0);
    md_op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Table of mult/div vectors: start, busy length, result.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, $sformatf("v%0d", i));
      wait_idle(n);
      chk($sformatf("v%0d busy_cycles", i), 32'(n), 32'(vecs[i].cyc));
      chk($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
    end

    // Divide by zero: full latency, HI/LO untouched.
    issue(4'd4, 32'd7, 32'd0, 1'b1, "div0");
    wait_idle(n);
    chk("div0 busy_cycles", 32'(n), 32'd10);
    chk("div0 hi", hi, 32'h00000001);
    chk("div0 lo", lo, 32'h7FFFFFFC);

    // mthi/mtlo and read port.
    issue(4'd5, 32'h0000AAAA, 32'd0, 1'b0, "mthi");
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi hi", hi, 32'h0000AAAA);
    issue(4'd6, 32'h00005555, 32'd0, 1'b0, "mtlo");
    chk("mtlo lo", lo, 32'h00005555);
    md_op = 4'd7; #1; chk("mfhi rdata", md_rdata, 32'h0000AAAA);
    md_op = 4'd8; #1; chk("mflo rdata", md_rdata, 32'h00005555);
    md_op = 4'd11; #1; chk("op11 rdata", md_rdata, 32'd0);
    md_op = 4'd0;
    tick();

    // Hazard: mtlo and mult while busy are ignored; in-flight mult retires on time.
    issue(4'd1, 32'd3, 32'd4, 1'b1, "hz");
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 1) begin md_op = 4'd6; src_a = 32'h1234; end
      else if (n == 2) begin md_op = 4'd1; src_a = 32'd7; src_b = 32'd7; end
      else md_op = 4'd0;
      #1;
      if (n <= 2) chk($sformatf("hz start c%0d", n), 32'(start), 32'd0);
      if (n == 3) chk("hz lo held", lo, 32'h00005555);
      if (n == 5) chk("hz no forward", md_rdata, 32'd0);
      tick();
    end
    md_op = 4'd0;
    chk("hz busy_cycles", 32'(n), 32'd5);
    chk("hz hi", hi, 32'd0);
    chk("hz lo", lo, 32'd12);

    // Cancel suppresses acceptance and mthi.
    cancel = 1'b1;
    issue(4'd1, 32'd9, 32'd9, 1'b0, "cancel mult");
    chk("cancel busy", 32'(busy), 32'd0);
    issue(4'd5, 32'h55, 32'd0, 1'b0, "cancel mthi");
    chk("cancel hi", hi, 32'd0);
    cancel = 1'b0;
    tick();
    chk("cancel lo", lo, 32'd12);

    // Reset during a divide aborts it and clears HI/LO.
    issue(4'd5, 32'h77, 32'd0, 1'b0, "pre mthi");
    chk("pre hi", hi, 32'h77);
    issue(4'd3, 32'd100, 32'd7, 1'b1, "rdiv");
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rdiv busy", 32'(busy), 32'd0);
    chk("rdiv hi", hi, 32'd0);
    chk("rdiv lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    md_op = 4'd8;
    #1;
    chk("rdiv mflo", md_rdata, 32'd0);
    md_op = 4'd0;
    for (int i = 0; i < 12; i++) tick();
    chk("rdiv late busy", 32'(busy), 32'd0);
    chk("rdiv late hi", hi, 32'd0);
    chk("rdiv late lo", lo, 32'd2 - 32'd2);

`ifdef MDU_MADD_EN
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, "madd mtlo");
    issue(4'd10, 32'd1, 32'd1, 1'b1, "maddu");
    wait_idle(n);
    chk("maddu busy_cycles", 32'(n), 32'd5);
    chk("maddu hi", hi, 32'd1);
    chk("maddu lo", lo, 32'd0);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 1'b1, "madd");
    wait_idle(n);
    chk("madd busy_cycles", 32'(n), 32'd5);
    chk("madd hi", hi, 32'd0);
    chk("madd lo", lo, 32'hFFFFFFFF);
`else
    issue(4'd9, 32'd1, 32'd1, 1'b0, "madd off");
    chk("madd off busy", 32'(busy), 32'd0);
    issue(4'd10, 32'd1, 32'd1, 1'b0, "maddu off");
    chk("maddu off hi", hi, 32'd0);
    chk("maddu off lo", lo, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
